// File: rtl/tone_detect_array.sv
// Per-channel tone qualifier: each band-pass input must stay high for HOLD_CYCLES to be detected.
// A live detection drops after RELEASE_CYCLES low; a sticky detection holds until clear. New detections pulse tone_valid.
module tone_detect_array #(
    parameter int N_CH           = 5,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int RELEASE_CYCLES = 2_500_000,
    parameter int CNT_W          = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] bp,
    input  logic            latch_mode,
    input  logic            clear,
    output logic [N_CH-1:0] detect,
    output logic            tone_valid,
    output logic [2:0]      tone_id,
    output logic [7:0]      led
);

    typedef enum logic [1:0] {IDLE, CHECK, DETECTED, RELEASE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic             tone_valid_q, tone_valid_d;
    logic [2:0]       tone_id_q, tone_id_d;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        tone_valid_d = 1'b0;
        tone_id_d    = 3'd0;
        // Walk downward so the lowest newly detected channel is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (bp[i]) begin
                        state_d[i] = CHECK;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                CHECK: begin
                    if (!bp[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == HOLD_LAST) begin
                        state_d[i]   = DETECTED;
                        cnt_d[i]     = '0;
                        tone_valid_d = 1'b1;
                        tone_id_d    = 3'(i);
                    end else begin
                        cnt_d[i] = inc_sat(cnt_q[i]);
                    end
                end
                DETECTED: begin
                    if (!latch_mode && !bp[i]) begin
                        state_d[i] = (RELEASE_CYCLES == 1) ? IDLE : RELEASE;
                        cnt_d[i]   = (RELEASE_CYCLES == 1) ? '0 : CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (latch_mode || bp[i]) begin
                        state_d[i] = DETECTED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == REL_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = inc_sat(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            if (clear) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end
        end
        if (clear) begin
            tone_valid_d = 1'b0;
            tone_id_d    = 3'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            tone_valid_q <= 1'b0;
            tone_id_q    <= 3'd0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            tone_valid_q <= tone_valid_d;
            tone_id_q    <= tone_id_d;
        end
    end

    always_comb begin
        led = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            detect[i]  = (state_q[i] == DETECTED) || (state_q[i] == RELEASE);
            led[7 - i] = detect[i];
        end
    end

    assign tone_valid = tone_valid_q;
    assign tone_id    = tone_id_q;

endmodule

// File: tb/tb_tone_detect_array.sv
// Bench for tone_detect_array: directed vector table, hand-written corner sequences,
// and a randomized run scored against a run-length reference model.
module tb_tone_detect_array;

    localparam int N = 5;
    localparam int H = 8;
    localparam int R = 4;

    logic         clock = 1'b0;
    logic         reset, latch_mode, clear;
    logic [N-1:0] bp;
    logic [N-1:0] detect;
    logic         tone_valid;
    logic [2:0]   tone_id;
    logic [7:0]   led;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: consecutive-high run while undetected, consecutive-low run while detected.
    bit m_det  [N];
    int m_hrun [N];
    int m_lrun [N];
    bit         m_vld;
    logic [2:0] m_id;

    tone_detect_array #(.N_CH(N), .HOLD_CYCLES(H), .RELEASE_CYCLES(R), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .bp         (bp),
        .latch_mode (latch_mode),
        .clear      (clear),
        .detect     (detect),
        .tone_valid (tone_valid),
        .tone_id    (tone_id),
        .led        (led)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] bp;
        logic         lm;
        logic         clr;
        logic         rst;
        logic [N-1:0] det;
        logic         vld;
        logic [2:0]   id;
        logic [7:0]   led;
    } vec_t;

    vec_t vt[$];

    function automatic logic [N-1:0] model_det();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_det[i];
        return v;
    endfunction

    function automatic logic [7:0] model_led();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < N; i++) v[7 - i] = m_det[i];
        return v;
    endfunction

    task automatic model_step(input logic [N-1:0] b, input logic lm, input logic clr, input logic rst);
        m_vld = 1'b0;
        m_id  = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (rst || clr) begin
                m_det[i]  = 1'b0;
                m_hrun[i] = 0;
                m_lrun[i] = 0;
            end else if (!m_det[i]) begin
                m_hrun[i] = b[i] ? m_hrun[i] + 1 : 0;
                if (m_hrun[i] == H) begin
                    m_det[i]  = 1'b1;
                    m_hrun[i] = 0;
                    m_lrun[i] = 0;
                    if (!m_vld) m_id = 3'(i);
                    m_vld = 1'b1;
                end
            end else begin
                m_lrun[i] = (lm || b[i]) ? 0 : m_lrun[i] + 1;
                if (m_lrun[i] == R) begin
                    m_det[i]  = 1'b0;
                    m_lrun[i] = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, clock, advance model, then compare outputs against the model.
    task automatic cyc(input logic [N-1:0] b, input logic lm, input logic clr, input logic rst);
        bp = b; latch_mode = lm; clear = clr; reset = rst;
        @(posedge clock);
        model_step(b, lm, clr, rst);
        #1;
        check("model_detect", 32'(detect), 32'(model_det()));
        check("model_valid", 32'(tone_valid), 32'(m_vld));
        check("model_id", 32'(tone_id), 32'(m_id));
        check("model_led", 32'(led), 32'(model_led()));
    endtask

    task automatic run(input int n, input logic [N-1:0] b, input logic lm);
        for (int k = 0; k < n; k++) cyc(b, lm, 1'b0, 1'b0);
    endtask

    initial begin
        bp = '0; latch_mode = 1'b0; clear = 1'b0; reset = 1'b1;

        // Single-channel hold, then two channels rising together.
        vt.push_back('{5'b00000, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 8'h00});
        for (int k = 0; k < H - 1; k++)
            vt.push_back('{5'b00001, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0, 8'h00});
        vt.push_back('{5'b00001, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b1, 3'd0, 8'h80});
        vt.push_back('{5'b00001, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b0, 3'd0, 8'h80});
        vt.push_back('{5'b00000, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 8'h00});
        for (int k = 0; k < H - 1; k++)
            vt.push_back('{5'b01010, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 3'd0, 8'h00});
        vt.push_back('{5'b01010, 1'b0, 1'b0, 1'b0, 5'b01010, 1'b1, 3'd1, 8'h50});
        vt.push_back('{5'b01010, 1'b0, 1'b0, 1'b0, 5'b01010, 1'b0, 3'd0, 8'h50});

        foreach (vt[j]) begin
            cyc(vt[j].bp, vt[j].lm, vt[j].clr, vt[j].rst);
            check("vec_detect", 32'(detect), 32'(vt[j].det));
            check("vec_valid", 32'(tone_valid), 32'(vt[j].vld));
            check("vec_id", 32'(tone_id), 32'(vt[j].id));
            check("vec_led", 32'(led), 32'(vt[j].led));
        end

        // Interrupted run needs a full fresh run.
        cyc('0, 1'b0, 1'b0, 1'b1);
        run(H - 1, 5'b00100, 1'b0);
        run(1, 5'b00000, 1'b0);
        check("gap_no_detect", 32'(detect), 32'h0);
        run(H - 1, 5'b00100, 1'b0);
        check("gap_short", 32'(detect), 32'h0);
        run(1, 5'b00100, 1'b0);
        check("gap_detect", 32'(detect), 32'h04);
        check("gap_valid", 32'(tone_valid), 32'h1);
        check("gap_id", 32'(tone_id), 32'h2);

        // Live mode: short drop is bridged, a full release drops the flag.
        cyc('0, 1'b0, 1'b0, 1'b1);
        run(H, 5'b10000, 1'b0);
        check("live_det", 32'(detect), 32'h10);
        run(R - 1, 5'b00000, 1'b0);
        check("live_hold_low", 32'(detect), 32'h10);
        run(1, 5'b10000, 1'b0);
        check("live_reentry_det", 32'(detect), 32'h10);
        check("live_reentry_nopulse", 32'(tone_valid), 32'h0);
        run(R - 1, 5'b00000, 1'b0);
        check("live_before_drop", 32'(detect), 32'h10);
        run(1, 5'b00000, 1'b0);
        check("live_dropped", 32'(detect), 32'h00);

        // Sticky mode, clear, and clear racing the final hold sample.
        cyc('0, 1'b1, 1'b0, 1'b1);
        run(H, 5'b00001, 1'b1);
        run(20, 5'b00000, 1'b1);
        check("sticky_hold", 32'(detect), 32'h01);
        cyc('0, 1'b1, 1'b1, 1'b0);
        check("sticky_clear", 32'(detect), 32'h00);
        run(H - 1, 5'b00001, 1'b1);
        cyc(5'b00001, 1'b1, 1'b1, 1'b0);
        check("clear_race_det", 32'(detect), 32'h00);
        check("clear_race_valid", 32'(tone_valid), 32'h0);
        run(1, 5'b00001, 1'b1);
        check("clear_race_restart", 32'(detect), 32'h00);

        // Reset mid-CHECK.
        cyc('0, 1'b0, 1'b0, 1'b1);
        run(6, 5'b00001, 1'b0);
        cyc(5'b00001, 1'b0, 1'b1, 1'b1);
        check("rst_mid_det", 32'(detect), 32'h0);
        check("rst_mid_led", 32'(led), 32'h0);
        run(H - 1, 5'b00001, 1'b0);
        check("rst_fresh_short", 32'(detect), 32'h0);
        run(1, 5'b00001, 1'b0);
        check("rst_fresh_det", 32'(detect), 32'h1);
        check("rst_fresh_valid", 32'(tone_valid), 32'h1);

        // Randomized runs with occasional mode changes, clears and resets.
        begin
            logic [N-1:0] lvl;
            int           left [N];
            logic         lm;
            lvl = '0;
            lm  = 1'b0;
            for (int i = 0; i < N; i++) left[i] = 0;
            for (int k = 0; k < 4000; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (left[i] == 0) begin
                        lvl[i]  = 1'($urandom_range(0, 1));
                        left[i] = $urandom_range(1, 14);
                    end
                    left[i]--;
                end
                if ($urandom_range(0, 199) == 0) lm = ~lm;
                cyc(lvl, lm, ($urandom_range(0, 299) == 0), ($urandom_range(0, 499) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
